// File: rtl/synth_ram_pkg.sv
// Shared types and widths for the synth_ram arbiter slice.
//   WORD_W : RAM data word width
//   BE_W   : number of byte write enables per word
//   port_t : requester index (two requesters)
//   rsp_t  : registered response descriptor {valid, port, err}
package synth_ram_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef logic port_t;

    typedef struct packed {
        logic  valid;
        port_t port;
        logic  err;
    } rsp_t;

endpackage

// File: rtl/synth_ram_arbiter_if.sv
// Requester-side bus of the synth_ram arbiter: request handshake plus the
// one-cycle-later response.
//   valid/ready  : request handshake, accepted when both are high
//   wen          : byte write enables, all zero means read
//   addr/wdata   : word address and write data
//   rvalid/rdata : response strobe and read data (old word for writes)
//   err          : response carries an out-of-range error
// Modports: master = requester, slave = arbiter.
interface synth_ram_arbiter_if #(
    parameter int ADDR_W = 22
);
    logic                             valid;
    logic                             ready;
    logic [synth_ram_pkg::BE_W-1:0]   wen;
    logic [ADDR_W-1:0]                addr;
    logic [synth_ram_pkg::WORD_W-1:0] wdata;
    logic                             rvalid;
    logic [synth_ram_pkg::WORD_W-1:0] rdata;
    logic                             err;

    modport master (
        output valid, wen, addr, wdata,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  valid, wen, addr, wdata,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
//   clk, resetn : clock, asynchronous active-low reset
//   req[1:0]    : request lines
//   gnt[1:0]    : combinational one-hot (or zero) grant
// The priority register starts at port 0 and, on every grant, moves to the
// port that was not granted; with no grant it holds.
module rr_arb2
    import synth_ram_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    port_t prio;

    always_comb begin
        gnt = 2'b00;
        if (req[0] && req[1]) begin
            gnt[prio] = 1'b1;
        end else begin
            gnt = req;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio <= 1'b0;
        end else if (gnt[0]) begin
            prio <= 1'b1;
        end else if (gnt[1]) begin
            prio <= 1'b0;
        end
    end

endmodule

// File: rtl/synth_ram_arbiter.sv
// Shares one single-port synth_ram (registered 1-cycle read) between two
// requesters. One access per cycle, round-robin on contention, response to
// the issuing port one cycle after acceptance. Out-of-range addresses are
// accepted but never reach the RAM; they answer with err = 1 and rdata = 0.
//   clk, resetn      : clock, asynchronous active-low reset
//   p0, p1           : requester buses (slave side)
//   ram_ena/ram_wen  : RAM enable and byte write enables
//   ram_addr         : RAM word address
//   ram_wdata        : RAM write data
//   ram_rdata        : RAM read data, valid the cycle after ram_ena
module synth_ram_arbiter
    import synth_ram_pkg::*;
#(
    parameter int WORDS  = 64,
    parameter int ADDR_W = 22
) (
    input  logic                clk,
    input  logic                resetn,
    synth_ram_arbiter_if.slave  p0,
    synth_ram_arbiter_if.slave  p1,
    output logic                ram_ena,
    output logic [BE_W-1:0]     ram_wen,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [WORD_W-1:0]   ram_wdata,
    input  logic [WORD_W-1:0]   ram_rdata
);

    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(WORDS);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       accept;
    port_t      gport;
    logic       in_range;
    rsp_t       rsp;

    // No grants while reset is held, even though resetn is asynchronous.
    assign req = {p1.valid, p0.valid} & {2{resetn}};

    rr_arb2 u_arb (
        .clk    (clk),
        .resetn (resetn),
        .req    (req),
        .gnt    (gnt)
    );

    assign p0.ready = gnt[0];
    assign p1.ready = gnt[1];
    assign accept   = |gnt;
    assign gport    = gnt[1];

    // Issue stage: mux the granted request onto the RAM.
    always_comb begin
        ram_addr  = gport ? p1.addr  : p0.addr;
        ram_wdata = gport ? p1.wdata : p0.wdata;
        in_range  = ram_addr < LIMIT;
        ram_ena   = accept && in_range;
        ram_wen   = ram_ena ? (gport ? p1.wen : p0.wen) : '0;
    end

    // Response stage: remember who was served and whether it was in range.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp <= '0;
        end else begin
            rsp.valid <= accept;
            rsp.port  <= gport;
            rsp.err   <= accept && !in_range;
        end
    end

    always_comb begin
        p0.rvalid = rsp.valid && (rsp.port == 1'b0);
        p1.rvalid = rsp.valid && (rsp.port == 1'b1);
        p0.err    = p0.rvalid && rsp.err;
        p1.err    = p1.rvalid && rsp.err;
        p0.rdata  = (p0.rvalid && !rsp.err) ? ram_rdata : '0;
        p1.rdata  = (p1.rvalid && !rsp.err) ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_synth_ram_arbiter.sv
// Directed bench for synth_ram_arbiter with a behavioural synth_ram model.
module tb_synth_ram_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ram_ena;
    logic [3:0]  ram_wen;
    logic [21:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    synth_ram_arbiter_if #(.ADDR_W(22)) p0_if ();
    synth_ram_arbiter_if #(.ADDR_W(22)) p1_if ();

    synth_ram_arbiter #(.WORDS(64), .ADDR_W(22)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .p0        (p0_if.slave),
        .p1        (p1_if.slave),
        .ram_ena   (ram_ena),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // synth_ram model: registered read, read-before-write, byte enables.
    logic [31:0] mem [0:63];
    logic        ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[5]     <= 32'h1234_5678;
            mem[63]    <= 32'hCAFE_F00D;
            ram_loaded <= 1'b1;
        end else if (ram_ena) begin
            ram_rdata <= mem[ram_addr[5:0]];
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) mem[ram_addr[5:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    task automatic idle();
        p0_if.valid = 1'b0; p0_if.wen = 4'h0; p0_if.addr = '0; p0_if.wdata = '0;
        p1_if.valid = 1'b0; p1_if.wen = 4'h0; p1_if.addr = '0; p1_if.wdata = '0;
    endtask

    task automatic test_reset();
        p0_if.valid = 1'b1; p0_if.addr = 22'd5;
        p1_if.valid = 1'b1; p1_if.addr = 22'd3;
        #2;
        for (int k = 0; k < 2; k++) begin
            checks++; if (p0_if.ready !== 1'b0) begin errors++; $display("FAIL rst_p0_ready: got %b want 0", p0_if.ready); end
            checks++; if (p1_if.ready !== 1'b0) begin errors++; $display("FAIL rst_p1_ready: got %b want 0", p1_if.ready); end
            checks++; if (ram_ena !== 1'b0) begin errors++; $display("FAIL rst_ram_ena: got %b want 0", ram_ena); end
            checks++; if ({p0_if.rvalid, p1_if.rvalid, p0_if.err, p1_if.err} !== 4'b0) begin errors++; $display("FAIL rst_rsp: got %b want 0000", {p0_if.rvalid, p1_if.rvalid, p0_if.err, p1_if.err}); end
            checks++; if ((p0_if.rdata | p1_if.rdata) !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", p0_if.rdata | p1_if.rdata); end
            @(posedge clk); @(negedge clk);
        end
        @(posedge clk); #1;
        idle();
        resetn = 1'b1;
    endtask

    task automatic test_read();
        @(posedge clk); #1;
        p0_if.valid = 1'b1; p0_if.addr = 22'd5; p0_if.wen = 4'h0;
        @(negedge clk);
        checks++; if (p0_if.ready !== 1'b1) begin errors++; $display("FAIL rd_p0_ready: got %b want 1", p0_if.ready); end
        checks++; if (ram_ena !== 1'b1) begin errors++; $display("FAIL rd_ram_ena: got %b want 1", ram_ena); end
        checks++; if (ram_addr !== 22'd5) begin errors++; $display("FAIL rd_ram_addr: got %0d want 5", ram_addr); end
        checks++; if (ram_wen !== 4'h0) begin errors++; $display("FAIL rd_ram_wen: got %h want 0", ram_wen); end
        checks++; if (p1_if.rvalid !== 1'b0) begin errors++; $display("FAIL rd_p1_rvalid_t: got %b want 0", p1_if.rvalid); end
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        checks++; if (p0_if.rvalid !== 1'b1) begin errors++; $display("FAIL rd_p0_rvalid: got %b want 1", p0_if.rvalid); end
        checks++; if (p0_if.rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_p0_rdata: got %h want 12345678", p0_if.rdata); end
        checks++; if (p0_if.err !== 1'b0) begin errors++; $display("FAIL rd_p0_err: got %b want 0", p0_if.err); end
        checks++; if (p1_if.rvalid !== 1'b0) begin errors++; $display("FAIL rd_p1_rvalid: got %b want 0", p1_if.rvalid); end
        @(posedge clk); @(negedge clk);
        checks++; if (p0_if.rvalid !== 1'b0) begin errors++; $display("FAIL rd_p0_rvalid_once: got %b want 0", p0_if.rvalid); end
    endtask

    task automatic test_write_merge();
        @(posedge clk); #1;
        p1_if.valid = 1'b1; p1_if.addr = 22'd3; p1_if.wen = 4'b0101; p1_if.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (p1_if.ready !== 1'b1) begin errors++; $display("FAIL wr_p1_ready: got %b want 1", p1_if.ready); end
        checks++; if (ram_wen !== 4'b0101) begin errors++; $display("FAIL wr_ram_wen: got %b want 0101", ram_wen); end
        checks++; if (ram_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_ram_wdata: got %h want deadbeef", ram_wdata); end
        @(posedge clk); #1;
        idle();
        p0_if.valid = 1'b1; p0_if.addr = 22'd3;
        @(negedge clk);
        checks++; if (p1_if.rvalid !== 1'b1) begin errors++; $display("FAIL wr_p1_rvalid: got %b want 1", p1_if.rvalid); end
        checks++; if (p1_if.rdata !== 32'h0) begin errors++; $display("FAIL wr_old_word: got %h want 0", p1_if.rdata); end
        checks++; if (p0_if.ready !== 1'b1) begin errors++; $display("FAIL wr_p0_ready: got %b want 1", p0_if.ready); end
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        checks++; if (p0_if.rdata !== 32'h00AD_00EF) begin errors++; $display("FAIL wr_merged: got %h want 00ad00ef", p0_if.rdata); end
        checks++; if (p1_if.rvalid !== 1'b0) begin errors++; $display("FAIL wr_p1_rvalid_off: got %b want 0", p1_if.rvalid); end
    endtask

    task automatic test_back_to_back();
        // Lone p1 access first so priority is back on port 0.
        @(posedge clk); #1;
        p1_if.valid = 1'b1; p1_if.addr = 22'd3;
        @(negedge clk);
        checks++; if (p1_if.ready !== 1'b1) begin errors++; $display("FAIL b2b_pre_ready: got %b want 1", p1_if.ready); end
        for (int i = 0; i < 6; i++) begin
            int g;
            int pv;
            g  = i % 2;
            pv = (i + 1) % 2;
            @(posedge clk); #1;
            p0_if.valid = 1'b1; p0_if.addr = 22'd5;
            p1_if.valid = 1'b1; p1_if.addr = 22'd3;
            @(negedge clk);
            checks++; if ({p1_if.ready, p0_if.ready} !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL b2b_grant[%0d]: got %b want port %0d", i, {p1_if.ready, p0_if.ready}, g); end
            checks++; if (ram_addr !== (g ? 22'd3 : 22'd5)) begin errors++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", i, ram_addr, g ? 3 : 5); end
            checks++; if ({p1_if.rvalid, p0_if.rvalid} !== (pv ? 2'b10 : 2'b01)) begin errors++; $display("FAIL b2b_rvalid[%0d]: got %b want port %0d", i, {p1_if.rvalid, p0_if.rvalid}, pv); end
            checks++; if ((pv ? p1_if.rdata : p0_if.rdata) !== (pv ? 32'h00AD_00EF : 32'h1234_5678)) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h", i, pv ? p1_if.rdata : p0_if.rdata); end
        end
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        checks++; if ({p1_if.rvalid, p0_if.rvalid} !== 2'b10) begin errors++; $display("FAIL b2b_last_rvalid: got %b want 10", {p1_if.rvalid, p0_if.rvalid}); end
    endtask

    task automatic test_range();
        @(posedge clk); #1;
        p0_if.valid = 1'b1; p0_if.addr = 22'd63;
        @(negedge clk);
        checks++; if (ram_ena !== 1'b1) begin errors++; $display("FAIL rng63_ena: got %b want 1", ram_ena); end
        @(posedge clk); #1;
        p0_if.addr = 22'd64;
        @(negedge clk);
        checks++; if ({p0_if.rvalid, p0_if.err} !== 2'b10) begin errors++; $display("FAIL rng63_rsp: got %b want rvalid=1 err=0", {p0_if.rvalid, p0_if.err}); end
        checks++; if (p0_if.rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rng63_rdata: got %h want cafef00d", p0_if.rdata); end
        checks++; if (p0_if.ready !== 1'b1) begin errors++; $display("FAIL rng64_ready: got %b want 1", p0_if.ready); end
        checks++; if (ram_ena !== 1'b0) begin errors++; $display("FAIL rng64_ena: got %b want 0", ram_ena); end
        @(posedge clk); #1;
        p0_if.addr = 22'h20_0000;
        @(negedge clk);
        checks++; if ({p0_if.rvalid, p0_if.err} !== 2'b11) begin errors++; $display("FAIL rng64_rsp: got %b want rvalid=1 err=1", {p0_if.rvalid, p0_if.err}); end
        checks++; if (p0_if.rdata !== 32'h0) begin errors++; $display("FAIL rng64_rdata: got %h want 0", p0_if.rdata); end
        checks++; if (ram_ena !== 1'b0) begin errors++; $display("FAIL rnghi_ena: got %b want 0", ram_ena); end
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        checks++; if ({p0_if.rvalid, p0_if.err} !== 2'b11) begin errors++; $display("FAIL rnghi_rsp: got %b want rvalid=1 err=1", {p0_if.rvalid, p0_if.err}); end
        checks++; if (p0_if.rdata !== 32'h0) begin errors++; $display("FAIL rnghi_rdata: got %h want 0", p0_if.rdata); end
    endtask

    task automatic test_reset_drop();
        @(posedge clk); #1;
        p0_if.valid = 1'b1; p0_if.addr = 22'd5;
        @(negedge clk);
        checks++; if (p0_if.ready !== 1'b1) begin errors++; $display("FAIL rdrop_ready: got %b want 1", p0_if.ready); end
        @(posedge clk); #1;
        idle();
        checks++; if (p0_if.rvalid !== 1'b1) begin errors++; $display("FAIL rdrop_rvalid_pre: got %b want 1", p0_if.rvalid); end
        #1 resetn = 1'b0;
        p0_if.valid = 1'b1; p0_if.addr = 22'd5;
        p1_if.valid = 1'b1; p1_if.addr = 22'd3;
        #1;
        checks++; if (p0_if.rvalid !== 1'b0) begin errors++; $display("FAIL rdrop_rvalid: got %b want 0", p0_if.rvalid); end
        checks++; if (p0_if.rdata !== 32'h0) begin errors++; $display("FAIL rdrop_rdata: got %h want 0", p0_if.rdata); end
        checks++; if ({p1_if.ready, p0_if.ready} !== 2'b00) begin errors++; $display("FAIL rdrop_ready_rst: got %b want 00", {p1_if.ready, p0_if.ready}); end
        #1 resetn = 1'b1;
        @(negedge clk);
        checks++; if ({p1_if.ready, p0_if.ready} !== 2'b01) begin errors++; $display("FAIL rdrop_first_grant: got %b want 01", {p1_if.ready, p0_if.ready}); end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_p1_only();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            p1_if.valid = 1'b1; p1_if.addr = 22'd7;
            @(negedge clk);
            checks++; if ({p1_if.ready, p0_if.ready} !== 2'b10) begin errors++; $display("FAIL p1only_grant[%0d]: got %b want 10", i, {p1_if.ready, p0_if.ready}); end
        end
        @(posedge clk); #1;
        p0_if.valid = 1'b1; p0_if.addr = 22'd5;
        @(negedge clk);
        checks++; if ({p1_if.ready, p0_if.ready} !== 2'b01) begin errors++; $display("FAIL p1only_then_p0: got %b want 01", {p1_if.ready, p0_if.ready}); end
        @(posedge clk); #1;
        idle();
        @(posedge clk);
    endtask

    initial begin
        idle();
        test_reset();
        test_read();
        test_write_merge();
        test_back_to_back();
        test_range();
        test_reset_drop();
        test_p1_only();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/synth_ram_arbiter.md
Name: synth_ram_arbiter

Overview:
- Shares one single-port synth_ram instance (32-bit words, 4 byte write enables, 1-cycle registered read) between two requesters, e.g. CPU data port and a DMA engine.
- Arbitrates round-robin, issues at most one RAM access per cycle, and routes read data back to the issuing port one cycle later.
- Rejects out-of-range addresses with an error response and never touches the RAM for them.

Parameters:
- WORDS, 64, RAM depth in 32-bit words; must match the attached synth_ram.
- ADDR_W, 22, requester and RAM address width.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- p0_valid  in  1  port 0 request valid
- p0_ready  out  1  port 0 request accepted this cycle
- p0_wen  in  4  port 0 byte write enables; 0 means read
- p0_addr  in  ADDR_W  port 0 word address
- p0_wdata  in  32  port 0 write data
- p0_rvalid  out  1  port 0 response valid
- p0_rdata  out  32  port 0 read data
- p0_err  out  1  port 0 response carries an out-of-range error
- p1_*  same set as p0_*, for port 1
- ram_ena  out  1  to synth_ram ena
- ram_wen  out  4  to synth_ram wen
- ram_addr  out  ADDR_W  to synth_ram addr
- ram_wdata  out  32  to synth_ram wdata
- ram_rdata  in  32  from synth_ram rdata

Behaviour:
Arbitration
- Combinational grant each cycle from p0_valid, p1_valid and the registered priority bit prio. After reset, prio = 0, i.e. port 0 is favoured.
- Exactly one port valid: that port is granted.
- Both ports valid: port prio is granted.
- Neither valid: no grant.
- pN_ready = grant to port N. A request is accepted in a cycle where pN_valid and pN_ready are both 1.
- Requesters must hold valid, addr, wen and wdata stable until accepted.
- On acceptance, prio <= the other port. With no acceptance, prio holds.

RAM issue
- Accepted, in range (addr < WORDS):
  - ram_ena = 1
  - ram_wen, ram_addr and ram_wdata are driven combinationally from the granted port.
- Accepted, out of range: ram_ena = 0.
- No grant: ram_ena = 0, ram_wen = 0; ram_addr and ram_wdata are don't-care.

Response
- On acceptance, register rsp_pend = 1, rsp_port and rsp_err.
- Next cycle, the port recorded in rsp_port gets pN_rvalid = 1 for exactly one cycle:
  - pN_rdata = ram_rdata, 0 if err.
  - pN_err = rsp_err.
- Responses arrive for writes too. For a write, rdata is the old word (read-before-write), matching RAM behaviour.
- Latency: acceptance in cycle T gives the response in cycle T+1.
- Throughput: 1 access per cycle. There is no response backpressure; requesters must sink responses.
- The non-target port sees rvalid = 0 and rdata = 0.

Reset
- resetn low asynchronously clears prio, rsp_pend, rsp_port and rsp_err.
- While resetn is low: all ready = 0, ram_ena = 0, all rvalid = 0, all rdata = 0, all err = 0. No grants are issued while in reset.
- Reset asserted in the cycle after an acceptance drops that response; the requester must re-issue.

Boundaries
- addr = WORDS-1 is valid.
- addr = WORDS is an error, and so are upper address bits that are set.
- Back-to-back alternating requests from both ports interleave 0,1,0,1.

Decomposition:
- Package synth_ram_pkg holds:
  - WORD_W = 32, BE_W = 4.
  - Port index typedef (1 bit).
  - Response struct {valid, port, err}.
- One sub-module, rr_arb2: two-input round-robin grant with priority register, about 40 lines. Reusable for later requester counts.
- The rest is a single always_ff for prio and the response register, plus combinational muxing.

Test Plan:
- Reset, then p0 reads addr 5 with no other traffic.
  - Expect: p0_ready = 1 in cycle T, ram_ena = 1 with ram_addr = 5 in cycle T.
  - Expect: p0_rvalid = 1 in T+1 with p0_rdata equal to the stored word; p1_rvalid = 0 throughout.
- p1 writes 0xDEADBEEF, wen = 4'b0101, to addr 3, then p0 reads addr 3.
  - Expect: 0x00AD00EF merged over a prior value of 0.
  - Expect: the write's own response returns the old word.
- Both valid continuously for 6 cycles.
  - Expect grants 0,1,0,1,0,1.
  - Expect responses on alternating ports one cycle after each grant; ready is never 1 on both ports at once.
- p0 request to addr 64 (WORDS = 64) and to 0x200000.
  - Expect: ram_ena = 0, p0_ready = 1, p0_rvalid = 1 next cycle with p0_err = 1 and p0_rdata = 0.
  - Expect: addr 63 succeeds with err = 0.
- Accept p0 in cycle T, pulse resetn low asynchronously mid-cycle T+1.
  - Expect: p0_rvalid drops to 0 immediately and prio = 0 after release.
  - Expect: the first grant after release with both ports valid goes to port 0.
- Only p1 valid for 3 cycles, then both valid.
  - Expect: p1 granted 3 times, then port 0 first, since prio flips after each p1 acceptance.
